// File: rtl/frac_lut4_acc_pkg.sv
// Shared definitions for the fractured-LUT4 accumulator slice.
// Holds the runtime op encodings and the upper bound on output pipeline depth.
package frac_lut4_acc_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOGIC = 2'd0;
  localparam op_t OP_ADD   = 2'd1;
  localparam op_t OP_ACC   = 2'd2;
  localparam op_t OP_LOAD  = 2'd3;

  localparam int unsigned OUT_PIPE_MAX = 2;

endpackage

// File: rtl/frac_lut4_acc_slice_if.sv
// Operand/result bundle for frac_lut4_acc_slice.
//   master: drives valid_i, op, cfg, a, b, cin; receives q, cout, ovf, valid_o
//   slave : the slice itself
interface frac_lut4_acc_slice_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid_i;
  logic [1:0]       op;
  logic [1:0]       cfg;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             ovf;
  logic             valid_o;

  modport master (
    output valid_i, op, cfg, a, b, cin,
    input  q, cout, ovf, valid_o
  );

  modport slave (
    input  valid_i, op, cfg, a, b, cin,
    output q, cout, ovf, valid_o
  );
endinterface

// File: rtl/frac_lut4_arith_bit.sv
// Combinational single-bit cell of the fractured-LUT4 slice.
//   a_i, b_eff_i : operand bits (b_eff_i is b in ADD/LOGIC, acc in ACC)
//   cin_i        : ripple carry in
//   cfg_i, op_i  : upper LUT inputs and runtime op
//   res_o        : next accumulator bit
//   cout_o       : ripple carry out (carry-follower form)
module frac_lut4_arith_bit
  import frac_lut4_acc_pkg::*;
#(
  parameter logic [15:0] LUT = 16'h0
) (
  input  logic       a_i,
  input  logic       b_eff_i,
  input  logic       cin_i,
  input  logic [1:0] cfg_i,
  input  op_t        op_i,
  output logic       res_o,
  output logic       cout_o
);

  logic prop;

  assign prop = a_i ^ b_eff_i;
  // Propagate forwards the incoming carry; otherwise both bits agree and
  // either one is the generated carry.
  assign cout_o = prop ? cin_i : (a_i & b_eff_i);

  always_comb begin
    res_o = prop ^ cin_i;
    case (op_i)
      OP_LOGIC: res_o = LUT[{cfg_i, b_eff_i, a_i}];
      OP_LOAD:  res_o = a_i;
      default:  res_o = prop ^ cin_i;
    endcase
  end

endmodule

// File: rtl/frac_lut4_acc_slice.sv
// Registered fractured-LUT4 arithmetic slice with internal accumulator.
//   C   : clock, rising edge
//   R   : asynchronous active-low reset
//   E   : clock enable; low freezes every register including pipe stages
//   bus : operand/op inputs and q/cout/ovf/valid_o results
// Results appear 1+OUT_PIPE enabled edges after acceptance. Accumulate
// feedback is always taken from the internal register, never a pipe stage.
module frac_lut4_acc_slice
  import frac_lut4_acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [15:0] LUT      = 16'h0,
  parameter int unsigned OUT_PIPE = 0
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  E,
  frac_lut4_acc_slice_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("frac_lut4_acc_slice: WIDTH must be 1..32");
  end
  if (OUT_PIPE > OUT_PIPE_MAX) begin : g_bad_pipe
    $error("frac_lut4_acc_slice: OUT_PIPE must be 0..2");
  end

  localparam int unsigned StW = WIDTH + 3;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   carry;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             vld_q;
  logic [StW-1:0]   st0;

  assign b_eff    = (bus.op == OP_ACC) ? acc_q : bus.b;
  assign carry[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    frac_lut4_arith_bit #(
      .LUT(LUT)
    ) u_bit (
      .a_i     (bus.a[i]),
      .b_eff_i (b_eff[i]),
      .cin_i   (carry[i]),
      .cfg_i   (bus.cfg),
      .op_i    (bus.op),
      .res_o   (res[i]),
      .cout_o  (carry[i+1])
    );
  end

  always_comb begin
    acc_d  = res;
    cout_d = 1'b0;
    ovf_d  = ovf_q;
    case (bus.op)
      OP_ADD: cout_d = carry[WIDTH];
      OP_ACC: begin
        cout_d = carry[WIDTH];
        ovf_d  = ovf_q | carry[WIDTH];
      end
      OP_LOAD: ovf_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      acc_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (E) begin
      vld_q <= bus.valid_i;
      if (bus.valid_i) begin
        acc_q  <= acc_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign st0 = {vld_q, ovf_q, cout_q, acc_q};

  if (OUT_PIPE == 0) begin : g_no_pipe
    assign {bus.valid_o, bus.ovf, bus.cout, bus.q} = st0;
  end else begin : g_pipe
    logic [StW-1:0] pipe_q [OUT_PIPE];

    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        for (int i = 0; i < int'(OUT_PIPE); i++) pipe_q[i] <= '0;
      end else if (E) begin
        pipe_q[0] <= st0;
        for (int i = 1; i < int'(OUT_PIPE); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign {bus.valid_o, bus.ovf, bus.cout, bus.q} = pipe_q[OUT_PIPE-1];
  end

endmodule

// File: tb/tb_frac_lut4_acc_slice.sv
// Self-checking bench for frac_lut4_acc_slice. Three instances share stimulus:
//   dut0: OUT_PIPE=0, LUT=16'h6666
//   dut1: OUT_PIPE=1, LUT=16'hF000
//   dut2: OUT_PIPE=2, LUT=16'h6666
// The model keeps, per instance, the op-level result history (plain arithmetic);
// instance d is expected to show the entry d enabled edges old.
module tb_frac_lut4_acc_slice;
  import frac_lut4_acc_pkg::*;

  localparam int W = 8;

  logic       C = 1'b0;
  logic       R;
  logic       E;
  logic       valid_i;
  logic [1:0] op;
  logic [1:0] cfg;
  logic [7:0] a, b;
  logic       cin;

  // Packed view {valid_o, ovf, cout, q}
  logic [10:0] obs  [3];
  logic [10:0] hist [3][3];

  int checks = 0;
  int errors = 0;

  always #5 C = ~C;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [15:0] L = (g == 1) ? 16'hF000 : 16'h6666;
    frac_lut4_acc_slice_if #(.WIDTH(W)) bus ();
    assign bus.valid_i = valid_i;
    assign bus.op      = op;
    assign bus.cfg     = cfg;
    assign bus.a       = a;
    assign bus.b       = b;
    assign bus.cin     = cin;
    frac_lut4_acc_slice #(
      .WIDTH   (W),
      .LUT     (L),
      .OUT_PIPE(g)
    ) u_dut (
      .C   (C),
      .R   (R),
      .E   (E),
      .bus (bus)
    );
    assign obs[g] = {bus.valid_o, bus.ovf, bus.cout, bus.q};
  end

  function automatic logic [10:0] next_stage0(int d, logic [10:0] cur);
    logic [15:0] lut;
    logic [8:0]  s;
    logic [7:0]  res;
    lut = (d == 1) ? 16'hF000 : 16'h6666;
    if (!valid_i) return {1'b0, cur[9:0]};
    case (op)
      OP_LOGIC: begin
        for (int i = 0; i < 8; i++) res[i] = lut[{cfg, b[i], a[i]}];
        return {1'b1, cur[9], 1'b0, res};
      end
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        return {1'b1, cur[9], s[8], s[7:0]};
      end
      OP_ACC: begin
        s = {1'b0, a} + {1'b0, cur[7:0]} + {8'd0, cin};
        return {1'b1, cur[9] | s[8], s[8], s[7:0]};
      end
      default: return {3'b100, a};
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 3; k++) hist[d][k] = '0;
  endtask

  task automatic tick();
    logic [10:0] nxt;
    @(posedge C);
    if (R && E) begin
      for (int d = 0; d < 3; d++) begin
        nxt        = next_stage0(d, hist[d][0]);
        hist[d][2] = hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = nxt;
      end
    end
    #1;
  endtask

  task automatic set_op(logic v, logic [1:0] o, logic [1:0] c, logic [7:0] av,
                        logic [7:0] bv, logic ci);
    valid_i = v; op = o; cfg = c; a = av; b = bv; cin = ci;
  endtask

  task automatic test_reset();
    R = 1'b0; E = 1'b1;
    set_op(1'b0, OP_LOGIC, 2'd0, 8'h00, 8'h00, 1'b0);
    model_clear();
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== 11'h0) begin
        errors++; $display("FAIL reset_hold dut%0d got %h want %h", d, obs[d], 11'h0);
      end
    end
    R = 1'b1;
    for (int n = 0; n < 8; n++) begin
      set_op(1'b1, 2'($urandom_range(0, 3)), 2'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom));
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== hist[d][d]) begin
          errors++; $display("FAIL pre_reset dut%0d got %h want %h", d, obs[d], hist[d][d]);
        end
      end
    end
    // Asynchronous pulse in the middle of the low phase
    @(negedge C); #2;
    R = 1'b0;
    #1;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== 11'h0) begin
        errors++; $display("FAIL async_reset dut%0d got %h want %h", d, obs[d], 11'h0);
      end
    end
    #1 R = 1'b1;
    set_op(1'b1, OP_ADD, 2'd0, 8'h12, 8'h34, 1'b1);
    for (int n = 1; n <= 3; n++) begin
      tick();
      set_op(1'b0, OP_LOGIC, 2'd0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (n < 3 && obs[2][10] !== 1'b0) begin
        errors++; $display("FAIL latency_early edge%0d got %b want 0", n, obs[2][10]);
      end
      if (n == 3 && obs[2] !== {3'b100, 8'h47}) begin
        errors++; $display("FAIL latency_add got %h want %h", obs[2], {3'b100, 8'h47});
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0]  ops  [5];
    logic [7:0]  as   [5];
    logic [7:0]  bs   [5];
    logic [10:0] want [5];
    ops = '{OP_LOAD, OP_ACC, OP_ACC, OP_ADD, OP_LOAD};
    as  = '{8'hFE, 8'h01, 8'h01, 8'h01, 8'h05};
    bs  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    want = '{{3'b100, 8'hFE}, {3'b100, 8'hFF}, {3'b111, 8'h00}, {3'b110, 8'h02},
             {3'b100, 8'h05}};
    E = 1'b1;
    for (int n = 0; n < 5; n++) begin
      set_op(1'b1, ops[n], 2'd0, as[n], bs[n], 1'b0);
      tick();
      checks++;
      if (obs[0] !== want[n]) begin
        errors++; $display("FAIL wrap step%0d got %h want %h", n, obs[0], want[n]);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== hist[d][d]) begin
          errors++; $display("FAIL wrap_model dut%0d got %h want %h", d, obs[d], hist[d][d]);
        end
      end
    end
  endtask

  task automatic test_logic();
    set_op(1'b1, OP_LOGIC, 2'd0, 8'hF0, 8'hCC, 1'b1);
    tick();
    checks++;
    if (obs[0] !== {3'b100, 8'h3C}) begin
      errors++; $display("FAIL logic_xor got %h want %h", obs[0], {3'b100, 8'h3C});
    end
    set_op(1'b1, OP_LOGIC, 2'd3, 8'h00, 8'h00, 1'b0);
    tick();
    set_op(1'b0, OP_LOGIC, 2'd0, 8'h00, 8'h00, 1'b0);
    tick();
    checks++;
    if (obs[1] !== {3'b100, 8'hFF}) begin
      errors++; $display("FAIL logic_cfg3 got %h want %h", obs[1], {3'b100, 8'hFF});
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== hist[d][d]) begin
        errors++; $display("FAIL logic_model dut%0d got %h want %h", d, obs[d], hist[d][d]);
      end
    end
  endtask

  task automatic test_gating();
    E = 1'b1;
    set_op(1'b1, OP_LOAD, 2'd0, 8'h00, 8'h00, 1'b0);
    tick();
    E = 1'b0;
    set_op(1'b1, OP_ACC, 2'd0, 8'h01, 8'h00, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (obs[0] !== {3'b100, 8'h00}) begin
        errors++; $display("FAIL gate_freeze cyc%0d got %h want %h", n, obs[0], {3'b100, 8'h00});
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== hist[d][d]) begin
          errors++; $display("FAIL gate_model dut%0d got %h want %h", d, obs[d], hist[d][d]);
        end
      end
    end
    E = 1'b1;
    set_op(1'b0, OP_ACC, 2'd0, 8'h01, 8'h00, 1'b0);
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (obs[2] !== 11'h0) begin
      errors++; $display("FAIL gate_idle got %h want %h", obs[2], 11'h0);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs[d] !== hist[d][d]) begin
        errors++; $display("FAIL idle_model dut%0d got %h want %h", d, obs[d], hist[d][d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         run = 0;
    int         best = 0;
    logic [7:0] last_q = 8'hXX;
    logic       last_ovf = 1'bx;
    E = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if (n == 0) set_op(1'b1, OP_LOAD, 2'd0, 8'h00, 8'h00, 1'b0);
      else if (n <= 10) set_op(1'b1, OP_ACC, 2'd0, 8'h03, 8'h00, 1'b0);
      else set_op(1'b0, OP_LOGIC, 2'd0, 8'h00, 8'h00, 1'b0);
      tick();
      if (obs[1][10] === 1'b1) begin
        run++;
        last_q   = obs[1][7:0];
        last_ovf = obs[1][9];
      end else begin
        run = 0;
      end
      if (run > best) best = run;
      checks++;
      if (obs[1] !== hist[1][1]) begin
        errors++; $display("FAIL b2b_model cyc%0d got %h want %h", n, obs[1], hist[1][1]);
      end
    end
    checks++;
    if (best != 11) begin
      errors++; $display("FAIL b2b_run got %0d want 11", best);
    end
    checks++;
    if (last_q !== 8'h1E || last_ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_final got q=%h ovf=%b want q=1e ovf=0", last_q, last_ovf);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      E = ($urandom_range(0, 5) != 0);
      set_op(1'($urandom_range(0, 4) != 0), 2'($urandom), 2'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom));
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== hist[d][d]) begin
          errors++; $display("FAIL random cyc%0d dut%0d got %h want %h", n, d, obs[d],
                             hist[d][d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_logic();
    test_gating();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
